rv32i_multicycle_ctrl: RTL

//  Multi-cycle RV32I control unit; successor to the single-cycle combinational decoder.

---
 rtl/rv32i_multicycle_ctrl_if.sv | 11 +
 rtl/rv32i_multicycle_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_ctrl_if.sv
// rtl/rv32i_multicycle_ctrl_if.sv - shared instruction/data memory port between control unit and memory
interface rv32i_multicycle_ctrl_if;
  logic        mem_req;
  logic        mem_ready;
  logic        AddrSel;
  logic        MemRW;
  logic [31:0] inst_in;

  modport master (output mem_req, AddrSel, MemRW, input mem_ready, inst_in);
  modport slave  (input mem_req, AddrSel, MemRW, output mem_ready, inst_in);
endinterface

// File: rtl/rv32i_multicycle_ctrl.sv
// rtl/rv32i_multicycle_ctrl.sv - multi-cycle RV32I control unit with IR, traps and retire counter
module rv32i_multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8,
  parameter int CNT_W          = 32,
  parameter int TRAP_EN        = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  rv32i_multicycle_ctrl_if.master  mem,
  input  logic                     BrEq_i,
  input  logic                     BrLT_i,
  input  logic                     BrGE_i,
  output logic                     PCSel_o,
  output logic [2:0]               ImmSel_o,
  output logic                     RegWEn_o,
  output logic                     BrUn_o,
  output logic                     ASel_o,
  output logic                     BSel_o,
  output logic [3:0]               ALUSel_o,
  output logic [1:0]               WBSel_o,
  output logic                     IRWEn_o,
  output logic                     PCWEn_o,
  output logic [31:0]              ir_o,
  output logic                     trap_o,
  output logic [1:0]               trap_cause_o,
  output logic [CNT_W-1:0]         instret_o,
  output logic [2:0]               state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b101
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b100;
  localparam logic [2:0] IMM_J = 3'b001;
  localparam logic [2:0] IMM_U = 3'b011;

  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_PASSB = 4'b0110;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam bit              TRAP_ON  = (TRAP_EN != 0);

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic              trap_q, trap_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [TO_W-1:0]   wait_q, wait_d;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = ir_q[6:0];
  assign f3     = ir_q[14:12];
  assign f7     = ir_q[31:25];

  logic [2:0] dec_imm;
  logic       dec_asel, dec_bsel, dec_regw, dec_jump, dec_branch, dec_load, dec_store, dec_illegal;
  logic [3:0] dec_alu;
  logic [1:0] dec_wb;
  logic       br_taken;
  logic       in_access, timeout_hit;

  // f3 to ALU encoding; alt selects sub/sra
  function automatic logic [3:0] alu_op(input logic [2:0] fn3, input logic alt);
    case (fn3)
      3'b000:  alu_op = alt ? 4'b0011 : 4'b0010;
      3'b001:  alu_op = 4'b1000;
      3'b010:  alu_op = 4'b0100;
      3'b011:  alu_op = 4'b1011;
      3'b100:  alu_op = 4'b0111;
      3'b101:  alu_op = alt ? 4'b1100 : 4'b1001;
      3'b110:  alu_op = 4'b0001;
      default: alu_op = 4'b0000;
    endcase
  endfunction

  // Instruction decode of IR into datapath selects and class flags
  always_comb begin
    dec_imm     = IMM_I;
    dec_asel    = 1'b0;
    dec_bsel    = 1'b0;
    dec_alu     = ALU_ADD;
    dec_wb      = 2'b00;
    dec_regw    = 1'b0;
    dec_jump    = 1'b0;
    dec_branch  = 1'b0;
    dec_load    = 1'b0;
    dec_store   = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OP_LUI: begin
        dec_imm = IMM_U; dec_bsel = 1'b1; dec_alu = ALU_PASSB; dec_wb = 2'b01; dec_regw = 1'b1;
      end
      OP_AUIPC: begin
        dec_imm = IMM_U; dec_asel = 1'b1; dec_bsel = 1'b1; dec_wb = 2'b01; dec_regw = 1'b1;
      end
      OP_JAL: begin
        dec_imm = IMM_J; dec_asel = 1'b1; dec_bsel = 1'b1; dec_wb = 2'b10; dec_regw = 1'b1;
        dec_jump = 1'b1;
      end
      OP_JALR: begin
        dec_bsel = 1'b1; dec_wb = 2'b10; dec_regw = 1'b1; dec_jump = 1'b1;
        dec_illegal = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        dec_imm = IMM_B; dec_asel = 1'b1; dec_bsel = 1'b1; dec_branch = 1'b1;
        dec_illegal = (f3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        dec_bsel = 1'b1; dec_load = 1'b1;
        dec_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        dec_imm = IMM_S; dec_bsel = 1'b1; dec_store = 1'b1;
        dec_illegal = (f3 > 3'b010);
      end
      OP_IMM: begin
        dec_bsel = 1'b1; dec_wb = 2'b01; dec_regw = 1'b1;
        dec_alu = alu_op(f3, (f3 == 3'b101) && f7[5]);
        dec_illegal = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                      ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
      end
      OP_REG: begin
        dec_wb = 2'b01; dec_regw = 1'b1;
        dec_alu = alu_op(f3, f7[5]);
        dec_illegal = ((f7 != 7'h00) && (f7 != 7'h20)) ||
                      ((f7 == 7'h20) && (f3 != 3'b000) && (f3 != 3'b101));
      end
      default: dec_illegal = 1'b1;
    endcase
    // An illegal word executed as NOP must not disturb any datapath select
    if (dec_illegal) begin
      dec_imm = IMM_I; dec_asel = 1'b0; dec_bsel = 1'b0; dec_alu = 4'b0000; dec_wb = 2'b00;
      dec_regw = 1'b0; dec_jump = 1'b0; dec_branch = 1'b0; dec_load = 1'b0; dec_store = 1'b0;
    end
  end

  // Branch condition per funct3: beq, bne, blt, bge, bltu, bgeu
  always_comb begin
    case (f3)
      3'b000:  br_taken = BrEq_i;
      3'b001:  br_taken = !BrEq_i;
      3'b100:  br_taken = BrLT_i;
      3'b101:  br_taken = BrGE_i;
      3'b110:  br_taken = BrLT_i;
      3'b111:  br_taken = !BrLT_i;
      default: br_taken = 1'b0;
    endcase
  end

  assign in_access   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout_hit = TO_EN && in_access && !mem.mem_ready && (wait_q == TO_LIMIT);

  // Sequencer: next state, strobes and control bus; everything zero while rst is high
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    trap_d       = trap_q;
    cause_d      = cause_q;
    instret_d    = instret_q;
    wait_d       = '0;
    PCSel_o      = 1'b0;
    ImmSel_o     = 3'b000;
    RegWEn_o     = 1'b0;
    BrUn_o       = 1'b0;
    ASel_o       = 1'b0;
    BSel_o       = 1'b0;
    ALUSel_o     = 4'b0000;
    WBSel_o      = 2'b00;
    IRWEn_o      = 1'b0;
    PCWEn_o      = 1'b0;
    mem.mem_req  = 1'b0;
    mem.AddrSel  = 1'b0;
    mem.MemRW    = 1'b0;
    if (!rst) begin
      if (in_access && !mem.mem_ready && !timeout_hit) begin
        wait_d = wait_q + 1'b1;
      end
      case (state_q)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ready) begin
            ir_d    = mem.inst_in;
            IRWEn_o = 1'b1;
            state_d = S_DECODE;
          end else if (timeout_hit) begin
            state_d = S_TRAP; trap_d = 1'b1; cause_d = 2'b10;
          end
        end
        S_DECODE: begin
          if (dec_illegal && TRAP_ON) begin
            state_d = S_TRAP; trap_d = 1'b1; cause_d = 2'b01;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          ImmSel_o = dec_imm;
          ASel_o   = dec_asel;
          BSel_o   = dec_bsel;
          ALUSel_o = dec_alu;
          BrUn_o   = dec_branch && f3[1];
          if (dec_load || dec_store) begin
            state_d = S_MEM;
          end else begin
            RegWEn_o = dec_regw;
            WBSel_o  = dec_wb;
            PCSel_o  = dec_jump || (dec_branch && br_taken);
            PCWEn_o  = 1'b1;
            state_d  = S_FETCH;
          end
        end
        S_MEM: begin
          ImmSel_o    = dec_imm;
          BSel_o      = 1'b1;
          ALUSel_o    = ALU_ADD;
          mem.mem_req = 1'b1;
          mem.AddrSel = 1'b1;
          mem.MemRW   = dec_store;
          if (mem.mem_ready) begin
            if (dec_store) begin
              PCWEn_o = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (timeout_hit) begin
            state_d = S_TRAP; trap_d = 1'b1; cause_d = 2'b10;
          end
        end
        S_WB: begin
          RegWEn_o = 1'b1;
          WBSel_o  = 2'b00;
          PCWEn_o  = 1'b1;
          state_d  = S_FETCH;
        end
        default: begin
          state_d = S_TRAP;
        end
      endcase
      if (PCWEn_o) begin
        instret_d = instret_q + 1'b1;
      end
    end
  end

  // State, IR, trap flags, retire and wait counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= 32'h0000_0013;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
      instret_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
    end
  end

  assign ir_o         = ir_q;
  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;
  assign instret_o    = instret_q;
  assign state_o      = state_q;

endmodule
